// File: rtl/fact_bus_if_if.sv
// fact_bus_if_if: processor data-memory bus bundle (we, a, wd in; rd out) with master/slave modports
interface fact_bus_if_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    modport master (output we, a, wd, input rd);
    modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/fact_bus_if.sv
// fact_bus_if: memory-mapped bridge from the processor bus to the factorial core, with watchdog
//   clk, rst (sync, active-high); bus (slave: we, a, wd -> rd)
//   fact_n, fact_go -> core; fact_done, fact_result <- core
//   irq: registered copy of done, only when FACT_IRQ_EN is defined (also enables STATUS write-to-clear)
module fact_bus_if #(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    fact_bus_if_if.slave    bus,
    output logic [3:0]      fact_n,
    output logic            fact_go,
    input  logic            fact_done,
    input  logic [31:0]     fact_result
`ifdef FACT_IRQ_EN
    ,
    output logic            irq
`endif
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    state_t      state, state_nx;
    logic [3:0]  n, n_nx;
    logic [31:0] result, result_nx;
    logic        done, done_nx, err, err_nx;
    logic [7:0]  wdog, wdog_nx;
    logic        busy, go_wr;
    wire unused_ok = ^bus.wd[31:4];
    assign busy    = state == START || state == WAIT;
    assign go_wr   = bus.we && bus.a == 2'd1 && bus.wd[0];
    assign fact_go = state == START;
    assign fact_n  = n;
    assign bus.rd  = bus.a == 2'd0 ? {28'd0, n} :
                     bus.a == 2'd2 ? {29'd0, busy, err, done} :
                     bus.a == 2'd3 ? result : 32'd0;
    always_comb begin
        state_nx  = state;
        n_nx      = n;
        result_nx = result;
        done_nx   = done;
        err_nx    = err;
        wdog_nx   = wdog;
        case (state)
            IDLE, DONE: begin
                if (bus.we && bus.a == 2'd0) n_nx = bus.wd[3:0];
`ifdef FACT_IRQ_EN
                if (bus.we && bus.a == 2'd2 && bus.wd[0]) done_nx = 1'b0;
`endif
                // 13! no longer fits in 32 bits, so reject without starting the core
                if (go_wr && n > 4'd12) begin
                    err_nx    = 1'b1;
                    done_nx   = 1'b1;
                    result_nx = 32'd0;
                    state_nx  = DONE;
                end else if (go_wr) begin
                    err_nx   = 1'b0;
                    done_nx  = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                wdog_nx  = 8'd0;
                state_nx = WAIT;
            end
            WAIT: begin
                wdog_nx = wdog == 8'hff ? wdog : wdog + 8'd1;
                // a core response wins over a watchdog expiry in the same cycle
                if (fact_done) begin
                    result_nx = fact_result;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end else if (wdog >= TLIM) begin
                    err_nx    = 1'b1;
                    done_nx   = 1'b1;
                    result_nx = 32'd0;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n      <= 4'd0;
            result <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
            wdog   <= 8'd0;
        end else begin
            state  <= state_nx;
            n      <= n_nx;
            result <= result_nx;
            done   <= done_nx;
            err    <= err_nx;
            wdog   <= wdog_nx;
        end
    end
`ifdef FACT_IRQ_EN
    always_ff @(posedge clk) irq <= rst ? 1'b0 : done;
`endif
endmodule

// File: doc/fact_bus_if.md
# fact_bus_if

Memory-mapped responder connecting the processor's data-memory bus to the factorial accelerator. Software writes the operand and a go bit, then polls status and reads the 32-bit result. Internally a small FSM issues a one-cycle start pulse to the factorial core, waits for its done level, latches the result, and runs a watchdog timeout. The block sits between the processor's address decoder and the factorial control unit/datapath pair.

## Interface
- TIMEOUT, 255: cycles allowed in WAIT before the request is aborted with error.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  bus write strobe, sampled each cycle. No read strobe; reads are combinational.
- a  input  2  word address: 0 = N, 1 = GO, 2 = STATUS, 3 = RESULT.
- wd  input  32  bus write data.
- rd  output  32  bus read data, combinational from `a`.
- fact_n  output  4  operand to the core; driven from the N register.
- fact_go  output  1  one-cycle start pulse to the core.
- fact_done  input  1  core done level; high from completion until the next fact_go.
- fact_result  input  32  core result; valid while fact_done is high.
- irq  output  1  interrupt. Present only with FACT_IRQ_EN.

## Operation
Register map (rd bit fields; unused bits read 0):
- N: bits [3:0]. Writable only when not busy.
- GO: reads 0. A write with wd[0]=1 requests a start.
- STATUS: bit0 = done, bit1 = err, bit2 = busy. Read-only.
- RESULT: last latched result. Read-only.

FSM states are IDLE, START, WAIT and DONE. busy = (state is START or WAIT).
- IDLE/DONE, GO write with wd[0]=1:
  - If N > 12, the result would overflow 32 bits. Set err=1, done=1, RESULT=0, stay or go to DONE. The core is not started.
  - Otherwise clear done and err, then go to START.
- START: fact_go=1 for exactly this cycle. Clear the watchdog counter, then go to WAIT.
- WAIT: the watchdog increments each cycle.
  - On the first cycle fact_done=1: latch fact_result into RESULT, set done=1, go to DONE.
  - If the watchdog reaches TIMEOUT first: set err=1, done=1, RESULT=0, go to DONE.
- While busy:
  - Writes to N and GO are ignored. There is no queueing.
  - A write to STATUS or RESULT is always ignored.
- N=0 is legal. The core returns 1.

## Timing
- Reset values: state=IDLE, N=0, RESULT=0, done=0, err=0, watchdog=0, fact_go=0, irq=0.
- A GO write in cycle t gives fact_go=1 in cycle t+1 and state WAIT in t+2.
- fact_done sampled high in cycle w makes RESULT and done visible on rd in cycle w+1.
- A GO write in the same cycle the FSM enters DONE is accepted on the next cycle only if it is still asserted. A GO write seen while in WAIT is dropped.
- Reset asserted mid-operation (any state) returns everything to reset values on the next edge. A subsequent fact_done from the abandoned run is ignored because the state is IDLE.
- The watchdog is 8 bits wide, saturating. TIMEOUT must be ≤ 255.

## Configuration
- FACT_IRQ_EN defined:
  - Port irq exists. irq = done, registered, so it rises the cycle after done sets.
  - A write to STATUS with wd[0]=1 clears done, and with it irq. err is unaffected.
- FACT_IRQ_EN undefined:
  - No irq port.
  - STATUS writes are ignored. done clears only on the next accepted GO.

## Test plan
- Reset, then read all four addresses → rd = 0 at each. fact_go stays 0.
- Write N=5, write GO=1; core model asserts done after 10 cycles with 120 → one fact_go pulse, busy=1 during wait, then RESULT=120 and STATUS=0x1.
- Write N=13, GO=1 → no fact_go, STATUS=0x3, RESULT=0.
- Start N=4, core never responds → STATUS=0x3 after TIMEOUT+2 cycles. A late fact_done pulse leaves RESULT=0.
- While busy, write N=7 and GO=1 → N reads back 4, only one fact_go pulse. After done, a GO write launches a new run with N=4.
- Assert rst in WAIT → next cycle STATUS=0, N=0, and a subsequent done is ignored. With FACT_IRQ_EN, irq rises one cycle after done, and a STATUS write of 1 drops it.
